// File: rtl/debug_controller.sv
// Debug command sequencer: pops UART command bytes, gates the CPU clock enable
// and hands one debug frame per stop to the transmitter. Optional run limit: DEBUG_RUN_LIMIT_EN.
module debug_controller #(
`ifdef DEBUG_RUN_LIMIT_EN
  parameter int unsigned MAX_RUN_CYCLES = 32'd1000000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  input  logic        cpu_halted,
  output logic        cpu_en,
  output logic        sendSignal,
  input  logic        dataSent,
  output logic        bad_cmd,
  output logic [2:0]  state,
  output logic [31:0] cycle_count
);

  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_RUN  = 8'h72;
  localparam logic [7:0] CMD_HALT = 8'h68;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_STEP      = 3'd2,
    S_RUN       = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_SENT = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cmd;
  logic        r_rd_uart;
  logic        r_cpu_en;
  logic        r_send;
  logic        r_bad;
  logic [31:0] r_cycle_count;
  logic        w_accept;
  logic        w_halt_byte;
  logic        w_bad_next;
  logic        w_limit;

  // A byte is taken only when the previous pop has completed, so one byte never pops twice.
  assign w_accept    = rx_ready && !r_rd_uart && (r_state == S_IDLE || r_state == S_RUN);
  assign w_halt_byte = w_accept && (r_data == CMD_HALT);

`ifdef DEBUG_RUN_LIMIT_EN
  logic [31:0] r_run_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run_cnt <= 32'd0;
    end else if (r_state != S_RUN && w_next == S_RUN) begin
      r_run_cnt <= 32'd0;
    end else if (r_state == S_RUN) begin
      r_run_cnt <= r_run_cnt + 32'd1;
    end
  end

  // The current RUN cycle is enabled, so the limit is reached one count early.
  assign w_limit = (r_state == S_RUN) && (r_run_cnt == MAX_RUN_CYCLES - 32'd1);
`else
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_bad_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (r_cmd)
          CMD_STEP: w_next = cpu_halted ? S_SEND : S_STEP;
          CMD_RUN:  w_next = cpu_halted ? S_SEND : S_RUN;
          CMD_DUMP: w_next = S_SEND;
          CMD_HALT: w_next = S_IDLE;
          default: begin
            w_next     = S_IDLE;
            w_bad_next = 1'b1;
          end
        endcase
      end
      S_STEP: w_next = S_SEND;
      S_RUN: begin
        if (cpu_halted || w_halt_byte || w_limit) w_next = S_SEND;
      end
      S_SEND: w_next = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (dataSent) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rd_uart     <= 1'b0;
      r_cpu_en      <= 1'b0;
      r_send        <= 1'b0;
      r_bad         <= 1'b0;
      r_cycle_count <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_rd_uart <= w_accept;
      r_cpu_en  <= (w_next == S_STEP) || (w_next == S_RUN);
      r_send    <= (w_next == S_SEND);
      r_bad     <= w_bad_next;
      if (r_cpu_en) r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_cmd <= r_data;
  end

  assign rd_uart     = r_rd_uart;
  assign cpu_en      = r_cpu_en;
  assign sendSignal  = r_send;
  assign bad_cmd     = r_bad;
  assign state       = r_state;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_debug_controller.sv
// Bench for debug_controller: UART byte queue, transmitter handshake and a
// command-level reference model of enabled cycles, frames and rejects.
module tb_debug_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  r_data = 8'h00;
  logic        cpu_halted = 1'b0;
  logic        dataSent = 1'b0;
  logic        rd_uart;
  logic        cpu_en;
  logic        sendSignal;
  logic        bad_cmd;
  logic [2:0]  state;
  logic [31:0] cycle_count;

`ifdef DEBUG_RUN_LIMIT_EN
  localparam bit          HAS_LIMIT = 1'b1;
  localparam int unsigned LIMIT     = 4;
  debug_controller #(.MAX_RUN_CYCLES(LIMIT)) dut (
    .clock(clock), .reset(reset), .rx_ready(rx_ready), .r_data(r_data),
    .rd_uart(rd_uart), .cpu_halted(cpu_halted), .cpu_en(cpu_en),
    .sendSignal(sendSignal), .dataSent(dataSent), .bad_cmd(bad_cmd),
    .state(state), .cycle_count(cycle_count)
  );
`else
  localparam bit          HAS_LIMIT = 1'b0;
  localparam int unsigned LIMIT     = 0;
  debug_controller dut (
    .clock(clock), .reset(reset), .rx_ready(rx_ready), .r_data(r_data),
    .rd_uart(rd_uart), .cpu_halted(cpu_halted), .cpu_en(cpu_en),
    .sendSignal(sendSignal), .dataSent(dataSent), .bad_cmd(bad_cmd),
    .state(state), .cycle_count(cycle_count)
  );
`endif

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // UART receive buffer: bench pushes, monitor pops on each rd_uart cycle.
  logic [7:0] wr_q[$];
  int rd_ptr = 0;

  int cyc_n = 0;
  int n_rd = 0, n_en = 0, n_send = 0, n_bad = 0;
  int rd_cyc = 0, en_first = 0, send_cyc = 0, bad_cyc = 0;
  logic [2:0] rd_state = 3'd0;
  logic rd_en = 1'b0, rd_prev_en = 1'b0, prev_en = 1'b0;
  logic [31:0] en_total = 32'd0;
  logic [31:0] exp_cc = 32'd0;
  int b_rd, b_en, b_send, b_bad;

  always @(negedge clock) begin
    cyc_n++;
    if (!reset) begin
      en_total = 32'd0;
      prev_en  = 1'b0;
    end else begin
      if (rd_uart) begin
        n_rd++;
        rd_cyc     = cyc_n;
        rd_state   = state;
        rd_en      = cpu_en;
        rd_prev_en = prev_en;
        rd_ptr++;
      end
      if (cpu_en) begin
        n_en++;
        en_total = en_total + 32'd1;
        if (!prev_en) en_first = cyc_n;
      end
      if (sendSignal) begin
        n_send++;
        send_cyc = cyc_n;
      end
      if (bad_cmd) begin
        n_bad++;
        bad_cyc = cyc_n;
      end
      prev_en = cpu_en;
    end
    rx_ready = (rd_ptr < wr_q.size());
    r_data   = rx_ready ? wr_q[rd_ptr] : 8'h00;
  end

  function automatic int unsigned run_expect(int unsigned n);
    if (HAS_LIMIT && n > LIMIT) return LIMIT;
    return n;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rd = n_rd; b_en = n_en; b_send = n_send; b_bad = n_bad;
  endtask

  task automatic push(logic [7:0] b);
    wr_q.push_back(b);
  endtask

  task automatic wait_send(int base);
    int k = 0;
    while (n_send == base && k < 100) begin cyc(1); k++; end
    chk("send_seen", 32'(n_send != base), 32'd1);
  endtask

  task automatic wait_en();
    int k = 0;
    while (!cpu_en && k < 20) begin cyc(1); k++; end
    chk("en_seen", 32'(cpu_en), 32'd1);
  endtask

  task automatic finish_frame();
    int d = int'($urandom_range(0, 4));
    cyc(d);
    dataSent = 1'b1;
    cyc(1);
    dataSent = 1'b0;
    chk("idle_after_sent", 32'(state), 32'd0);
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_rd_uart"}, 32'(rd_uart), 32'd0);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    chk({tag, "_send"}, 32'(sendSignal), 32'd0);
    chk({tag, "_bad"}, 32'(bad_cmd), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_cycles"}, cycle_count, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int unsigned n;
    reset = 1'b0;
    cyc(3);
    check_reset_vals("por");
    reset = 1'b1;
    cyc(2);

    repeat ($urandom_range(2, 4)) begin
      snap();
      push(8'h73);
      wait_send(b_send);
      chk("step_decode_state", 32'(rd_state), 32'd1);
      chk("step_en_latency", 32'(en_first - rd_cyc), 32'd1);
      chk("step_send_latency", 32'(send_cyc - rd_cyc), 32'd2);
      chk("step_en_cycles", 32'(n_en - b_en), 32'd1);
      finish_frame();
      exp_cc = exp_cc + 32'd1;
      chk("step_cycle_count", cycle_count, exp_cc);
      chk("step_sends", 32'(n_send - b_send), 32'd1);
    end

    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? 50 : $urandom_range(2, 30);
      snap();
      push(8'h72);
      wait_en();
      for (int s = 1; s < int'(n); s++) cyc(1);
      cpu_halted = 1'b1;
      wait_send(b_send);
      cpu_halted = 1'b0;
      finish_frame();
      exp_cc = exp_cc + run_expect(n);
      chk("run_en_cycles", 32'(n_en - b_en), run_expect(n));
      chk("run_cycle_count", cycle_count, exp_cc);
      chk("run_sends", 32'(n_send - b_send), 32'd1);
    end

    for (int i = 0; i < 2; i++) begin
      cpu_halted = 1'b1;
      snap();
      push(i == 0 ? 8'h73 : 8'h72);
      wait_send(b_send);
      cpu_halted = 1'b0;
      finish_frame();
      chk("halted_entry_en", 32'(n_en - b_en), 32'd0);
      chk("halted_entry_sends", 32'(n_send - b_send), 32'd1);
    end

`ifndef DEBUG_RUN_LIMIT_EN
    snap();
    push(8'h72);
    wait_en();
    cyc(5);
    push(8'h41);
    cyc(8);
    chk("run_discard_bad", 32'(n_bad - b_bad), 32'd0);
    chk("run_discard_pop", 32'(n_rd - b_rd), 32'd2);
    chk("run_discard_state", 32'(state), 32'd3);
    push(8'h68);
    wait_send(b_send);
    chk("halt_byte_state", 32'(rd_state), 32'd4);
    chk("halt_byte_en_off", 32'(rd_en), 32'd0);
    chk("halt_byte_en_before", 32'(rd_prev_en), 32'd1);
    finish_frame();
    chk("halt_byte_bad", 32'(n_bad - b_bad), 32'd0);
    chk("halt_byte_sends", 32'(n_send - b_send), 32'd1);
    exp_cc = exp_cc + 32'(n_en - b_en);
    chk("halt_byte_cycles", cycle_count, exp_cc);
`else
    snap();
    push(8'h72);
    wait_send(b_send);
    finish_frame();
    chk("limit_en_cycles", 32'(n_en - b_en), LIMIT);
    exp_cc = exp_cc + LIMIT;
    chk("limit_cycle_count", cycle_count, exp_cc);
`endif

    snap();
    push(8'h64);
    push(8'h7A);
    wait_send(b_send);
    cyc(3);
    chk("dump_z_held", 32'(n_rd - b_rd), 32'd1);
    chk("dump_z_waiting", 32'(rx_ready), 32'd1);
    finish_frame();
    cyc(4);
    chk("dump_en", 32'(n_en - b_en), 32'd0);
    chk("dump_sends", 32'(n_send - b_send), 32'd1);
    chk("z_bad_count", 32'(n_bad - b_bad), 32'd1);
    chk("z_bad_latency", 32'(bad_cyc - rd_cyc), 32'd1);

    repeat (3) begin
      do b = 8'($urandom_range(0, 255));
      while (b == 8'h73 || b == 8'h72 || b == 8'h68 || b == 8'h64);
      snap();
      push(b);
      cyc(6);
      chk("rand_bad_count", 32'(n_bad - b_bad), 32'd1);
      chk("rand_bad_sends", 32'(n_send - b_send), 32'd0);
      chk("rand_bad_state", 32'(state), 32'd0);
    end

    snap();
    push(8'h68);
    cyc(6);
    chk("idle_halt_pop", 32'(n_rd - b_rd), 32'd1);
    chk("idle_halt_bad", 32'(n_bad - b_bad), 32'd0);
    chk("idle_halt_sends", 32'(n_send - b_send), 32'd0);

    dataSent = 1'b1;
    snap();
    push(8'h64);
    for (int k = 0; k < 20 && !sendSignal; k++) cyc(1);
    chk("held_sent_send", 32'(state), 32'd4);
    cyc(1);
    chk("held_sent_wait", 32'(state), 32'd5);
    cyc(1);
    chk("held_sent_idle", 32'(state), 32'd0);
    dataSent = 1'b0;

    push(8'h72);
    wait_en();
    cyc(3);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_run");
    exp_cc = 32'd0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    chk("rst_run_stays_idle", 32'(state), 32'd0);

    snap();
    push(8'h64);
    wait_send(b_send);
    chk("rst_wait_state", 32'(state), 32'd5);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_wait");
    cyc(1);
    reset = 1'b1;
    cyc(1);
    dataSent = 1'b1;
    cyc(1);
    dataSent = 1'b0;
    cyc(3);
    chk("late_sent_state", 32'(state), 32'd0);
    chk("late_sent_sends", 32'(n_send - b_send), 32'd1);
    chk("final_cycle_count", cycle_count, exp_cc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
